// File: rtl/alu_issue_buffer.sv
// Request FIFO that feeds a slow ALU, sending at most one operation every 3 cycles.
// Define ALU_ISSUE_BUFFER_STATS_EN to add the ISSUE_CNT/STALL_CNT counters.
module alu_issue_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VLD,
  output logic                  IN_RDY,
  input  logic [3:0]            IN_OP,
  input  logic [1:0]            IN_MOVI,
  input  logic [DATA_WIDTH-1:0] IN_A,
  input  logic [DATA_WIDTH-1:0] IN_B,
  input  logic [DATA_WIDTH-1:0] IN_MEM,
  input  logic [DATA_WIDTH-1:0] IN_IMM,
  output logic                  ACT,
  output logic [3:0]            OP,
  output logic [1:0]            MOVI,
  output logic [DATA_WIDTH-1:0] REG_A,
  output logic [DATA_WIDTH-1:0] REG_B,
  output logic [DATA_WIDTH-1:0] MEM,
  output logic [DATA_WIDTH-1:0] IMM,
  input  logic                  ALU_RDY
`ifdef ALU_ISSUE_BUFFER_STATS_EN
  ,
  output logic [15:0]           ISSUE_CNT,
  output logic [15:0]           STALL_CNT
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = 6 + 4 * DATA_WIDTH;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_e;

  state_e          state_q;
  logic [AW:0]     cnt_q;
  logic [AW:0]     cnt_d;
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [PW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   in_pkt;
  logic [PW-1:0]   pl_q;
  logic            act_q;
  logic            push;
  logic            pop;

  assign in_pkt = {IN_OP, IN_MOVI, IN_A, IN_B, IN_MEM, IN_IMM};
  assign IN_RDY = (cnt_q < FULL);
  assign push   = IN_VLD & IN_RDY;
  assign pop    = (state_q == IDLE) && (cnt_q != '0) && ALU_RDY;

  assign ACT = act_q;
  assign {OP, MOVI, REG_A, REG_B, MEM, IMM} = pl_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_q] <= in_pkt;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      act_q   <= 1'b0;
      pl_q    <= '0;
    end else begin
      act_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= ISSUE;
            act_q   <= 1'b1;
            pl_q    <= mem_q[rd_q];
          end
        end
        ISSUE:   state_q <= HOLD;
        HOLD:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_BUFFER_STATS_EN
  logic [15:0] issue_cnt_q;
  logic [15:0] stall_cnt_q;

  assign ISSUE_CNT = issue_cnt_q;
  assign STALL_CNT = stall_cnt_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (act_q && (issue_cnt_q != 16'hFFFF)) begin
        issue_cnt_q <= issue_cnt_q + 16'd1;
      end
      if (IN_VLD && !IN_RDY && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_buffer.sv
// Self-checking bench for alu_issue_buffer: vector table, scoreboard,
// and hand-written fill/drain, push+pop, reset and wrap sequences.
module tb_alu_issue_buffer;

  localparam int DW = 8;
  localparam int PW = 6 + 4 * DW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IN_VLD;
  logic          IN_RDY;
  logic [3:0]    IN_OP;
  logic [1:0]    IN_MOVI;
  logic [DW-1:0] IN_A, IN_B, IN_MEM, IN_IMM;
  logic          ACT;
  logic [3:0]    OP;
  logic [1:0]    MOVI;
  logic [DW-1:0] REG_A, REG_B, MEM, IMM;
  logic          ALU_RDY;
`ifdef ALU_ISSUE_BUFFER_STATS_EN
  logic [15:0]   ISSUE_CNT, STALL_CNT;
`endif

  int checks = 0;
  int errors = 0;
  int act_cnt = 0;
  logic act_prev = 1'b0;
  logic [PW-1:0] sb [$];

  alu_issue_buffer #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VLD(IN_VLD), .IN_RDY(IN_RDY),
    .IN_OP(IN_OP), .IN_MOVI(IN_MOVI),
    .IN_A(IN_A), .IN_B(IN_B),
    .IN_MEM(IN_MEM), .IN_IMM(IN_IMM),
    .ACT(ACT), .OP(OP), .MOVI(MOVI),
    .REG_A(REG_A), .REG_B(REG_B),
    .MEM(MEM), .IMM(IMM),
    .ALU_RDY(ALU_RDY)
`ifdef ALU_ISSUE_BUFFER_STATS_EN
    ,
    .ISSUE_CNT(ISSUE_CNT),
    .STALL_CNT(STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  // Inputs only change at posedge+1, so the negedge sees the handshake
  // values that the next rising edge will act on.
  always @(negedge CLK) begin
    if (RST) begin
      if (IN_VLD && IN_RDY) begin
        sb.push_back({IN_OP, IN_MOVI, IN_A, IN_B, IN_MEM, IN_IMM});
      end
      if (ACT) begin
        act_cnt++;
        chk("act_b2b", 64'(act_prev), 64'd0);
        if (sb.size() == 0) begin
          chk("sb_empty_on_act", 64'(sb.size()), 64'd1);
        end else begin
          chk("sb_payload", 64'({OP, MOVI, REG_A, REG_B, MEM, IMM}),
              64'(sb.pop_front()));
        end
      end
      act_prev = ACT;
    end else begin
      act_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_wait(input logic [7:0] a);
    logic r;
    logic ok;
    ok = 1'b0;
    IN_VLD  = 1'b1;
    IN_OP   = a[3:0];
    IN_MOVI = a[5:4];
    IN_A    = a;
    IN_B    = ~a;
    IN_MEM  = a ^ 8'h5A;
    IN_IMM  = a + 8'd1;
    for (int k = 0; k < 40 && !ok; k++) begin
      r = IN_RDY;
      tick();
      if (r) ok = 1'b1;
    end
    IN_VLD = 1'b0;
    if (!ok) chk("push_timeout", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    ALU_RDY = 1'b1;
    for (int k = 0; k < 200 && sb.size() != 0; k++) tick();
    repeat (3) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [1:0] movi;
    logic [7:0] a, b, mem, imm;
    logic [3:0] e_op;
    logic [1:0] e_movi;
    logic [7:0] e_a, e_b, e_imm;
  } vec_t;

  localparam int NV = 4;
  vec_t tv [NV];

  initial begin
    int acts[$];
    int acc;
    int n0;
    logic r;

    tv[0] = '{4'h2, 2'd0, 8'h05, 8'h03, 8'h00, 8'h00,
              4'h2, 2'd0, 8'h05, 8'h03, 8'h00};
    tv[1] = '{4'hF, 2'd3, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              4'hF, 2'd3, 8'hFF, 8'hFF, 8'hFF};
    tv[2] = '{4'h0, 2'd1, 8'h00, 8'h80, 8'h5A, 8'h01,
              4'h0, 2'd1, 8'h00, 8'h80, 8'h01};
    tv[3] = '{4'hA, 2'd2, 8'hA5, 8'h5A, 8'h3C, 8'hC3,
              4'hA, 2'd2, 8'hA5, 8'h5A, 8'hC3};

    RST = 1'b0; ALU_RDY = 1'b0; IN_VLD = 1'b0;
    IN_OP = '0; IN_MOVI = '0; IN_A = '0; IN_B = '0;
    IN_MEM = '0; IN_IMM = '0;

    repeat (2) tick();
    chk("rst_act", 64'(ACT), 64'd0);
    chk("rst_rdy", 64'(IN_RDY), 64'd1);
    chk("rst_op", 64'(OP), 64'd0);
    chk("rst_a", 64'(REG_A), 64'd0);
    RST = 1'b1;

    // single requests: latency 2, one-cycle ACT, stable payload after
    ALU_RDY = 1'b1;
    for (int i = 0; i < NV; i++) begin
      IN_VLD = 1'b1;
      IN_OP = tv[i].op; IN_MOVI = tv[i].movi;
      IN_A = tv[i].a; IN_B = tv[i].b;
      IN_MEM = tv[i].mem; IN_IMM = tv[i].imm;
      tick();
      IN_VLD = 1'b0;
      chk("lat_early", 64'(ACT), 64'd0);
      tick();
      chk("lat_act", 64'(ACT), 64'd1);
      chk("v_op", 64'(OP), 64'(tv[i].e_op));
      chk("v_movi", 64'(MOVI), 64'(tv[i].e_movi));
      chk("v_a", 64'(REG_A), 64'(tv[i].e_a));
      chk("v_b", 64'(REG_B), 64'(tv[i].e_b));
      chk("v_imm", 64'(IMM), 64'(tv[i].e_imm));
      tick();
      chk("hold_act", 64'(ACT), 64'd0);
      chk("hold_a", 64'(REG_A), 64'(tv[i].e_a));
      tick();
    end
`ifdef ALU_ISSUE_BUFFER_STATS_EN
    chk("issue_cnt_tbl", 64'(ISSUE_CNT), 64'(NV));
`endif

    // fill with ALU stalled, fifth request held off
    ALU_RDY = 1'b0;
    IN_VLD = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      IN_A = 8'(i); IN_OP = 4'(i);
      tick();
    end
    chk("full_rdy", 64'(IN_RDY), 64'd0);
    IN_A = 8'd5; IN_OP = 4'd5;
    repeat (3) tick();
    chk("held_rdy", 64'(IN_RDY), 64'd0);
    chk("fill_sb", 64'(sb.size()), 64'd4);
`ifdef ALU_ISSUE_BUFFER_STATS_EN
    chk("stall_cnt", 64'(STALL_CNT), 64'd3);
`endif
    ALU_RDY = 1'b1;
    acc = -1;
    r = IN_RDY;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (IN_VLD && r) begin
        acc = c;
        IN_VLD = 1'b0;
      end
      if (ACT) begin
        acts.push_back(c);
        chk("drain_a", 64'(REG_A), 64'(acts.size()));
      end
      r = IN_RDY;
    end
    chk("drain_n", 64'(acts.size()), 64'd5);
    if (acts.size() == 5) begin
      for (int k = 1; k < 5; k++)
        chk("drain_gap", 64'(acts[k] - acts[0]), 64'(3 * k));
      chk("fifth_acc", 64'(acc), 64'(acts[0] + 1));
    end
    chk("drain_sb", 64'(sb.size()), 64'd0);

    // push and pop on the same edge at count=2
    ALU_RDY = 1'b0;
    push_wait(8'h10);
    push_wait(8'h11);
    IN_VLD = 1'b1;
    IN_A = 8'h12; IN_OP = 4'h2; IN_MOVI = 2'd1;
    IN_B = 8'hED; IN_MEM = 8'h48; IN_IMM = 8'h13;
    ALU_RDY = 1'b1;
    tick();
    IN_VLD = 1'b0;
    ALU_RDY = 1'b0;
    chk("pp_act", 64'(ACT), 64'd1);
    chk("pp_a", 64'(REG_A), 64'h10);
    push_wait(8'h13);
    push_wait(8'h14);
    chk("pp_full", 64'(IN_RDY), 64'd0);
    drain();

    // reset while in HOLD with three entries left
    ALU_RDY = 1'b0;
    for (int i = 0; i < 4; i++) push_wait(8'(8'h20 + i));
    ALU_RDY = 1'b1;
    tick();
    ALU_RDY = 1'b0;
    chk("rh_issue", 64'(ACT), 64'd1);
    tick();
    chk("rh_hold", 64'(ACT), 64'd0);
    RST = 1'b0;
    #1;
    chk("rh_act", 64'(ACT), 64'd0);
    chk("rh_a", 64'(REG_A), 64'd0);
    chk("rh_op", 64'(OP), 64'd0);
    chk("rh_imm", 64'(IMM), 64'd0);
    chk("rh_rdy", 64'(IN_RDY), 64'd1);
    sb.delete();
    tick();
    RST = 1'b1;
    n0 = act_cnt;
    ALU_RDY = 1'b1;
    repeat (6) tick();
    chk("rh_quiet", 64'(act_cnt - n0), 64'd0);
    push_wait(8'h30);
    chk("rh_lat_early", 64'(ACT), 64'd0);
    tick();
    chk("rh_lat_act", 64'(ACT), 64'd1);
    chk("rh_lat_a", 64'(REG_A), 64'h30);
    drain();

    // ten requests through the wrapping pointers
    RST = 1'b0;
    tick();
    RST = 1'b1;
    sb.delete();
    n0 = act_cnt;
    ALU_RDY = 1'b1;
    for (int i = 0; i < 10; i++) push_wait(8'($urandom));
    drain();
    chk("wrap_acts", 64'(act_cnt - n0), 64'd10);
`ifdef ALU_ISSUE_BUFFER_STATS_EN
    chk("wrap_issue_cnt", 64'(ISSUE_CNT), 64'd10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
